flp_result_sink: RTL and testbench

// - Receiving end of the floating-point FIR output stream: captures each {out, valid} result from FIR_Flp.
// - Converts the IEEE-style float (sign|exp|mant) to saturated signed fixed point.
// - Buffers results in a FIFO and drains them to a downstream consumer (DAC/serializer) over valid/ready.
// - Decouples the filter's DSR-paced output from the consumer's back-pressure.

---
 rtl/flp_result_sink.sv | 178 +++++++++++++++++
 tb/tb_flp_result_sink.sv | 295 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/flp_result_sink.sv
// flp_result_sink: receives the float FIR output stream, converts each sample to
// saturated signed fixed point through a 2-stage pipeline and buffers it in a
// circular FIFO drained over a valid/ready handshake.
// Optional feature: define FLP_SINK_DROPCNT_EN to add a saturating 16-bit
// dropped-sample counter output (drop_cnt).
module flp_result_sink #(
  parameter int unsigned n_exp  = 8,
  parameter int unsigned n_mant = 23,
  parameter int unsigned W_OUT  = 16,
  parameter int unsigned F_FRAC = 14,
  parameter int unsigned DEPTH  = 8
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic [n_exp+n_mant:0]        in,
  input  logic                         valid,
  output logic [W_OUT-1:0]             out_data,
  output logic                         out_valid,
  input  logic                         out_ready,
  output logic [$clog2(DEPTH+1)-1:0]   level,
  output logic                         sat,
  output logic                         overrun
`ifdef FLP_SINK_DROPCNT_EN
  ,
  output logic [15:0]                  drop_cnt
`endif
);

  localparam int unsigned LW   = $clog2(DEPTH + 1);
  localparam int unsigned PW   = $clog2(DEPTH);
  localparam int unsigned XW   = n_mant + 1 + W_OUT;
  localparam int          BIAS = int'(2 ** (n_exp - 1)) - 1;
  localparam logic [W_OUT-1:0] MAXP = {1'b0, {(W_OUT - 1){1'b1}}};

  logic                in_sign;
  logic [n_exp-1:0]    in_exp;
  logic [n_mant-1:0]   in_mant;

  logic [W_OUT-1:0]    s1_mag_c;
  logic [XW-1:0]       ext_c;
  int                  lead_c;

  logic                s1_vld;
  logic                s1_sign;
  logic [W_OUT-1:0]    s1_mag;

  logic                clamp_c;
  logic [W_OUT-1:0]    abs_c;
  logic [W_OUT-1:0]    s2_data_c;

  logic                s2_vld;
  logic [W_OUT-1:0]    s2_data;

  logic [W_OUT-1:0]    mem [DEPTH];
  logic [PW-1:0]       rd_ptr;
  logic [PW-1:0]       wr_ptr;

  logic                pop_c;
  logic                full_c;
  logic                push_c;
  logic                drop_c;
  logic [PW-1:0]       rd_nxt_c;
  logic [LW-1:0]       level_nxt_c;
  logic [LW-1:0]       remain_c;
  logic [W_OUT-1:0]    head_nxt_c;

  assign in_sign = in[n_exp+n_mant];
  assign in_exp  = in[n_exp+n_mant-1:n_mant];
  assign in_mant = in[n_mant-1:0];

  // S1 decode: align {1,mant} so the LSB weighs 2**-F_FRAC, truncating toward zero.
  // lead_c is the bit position of the hidden one in the fixed-point result.
  always_comb begin
    s1_mag_c = '0;
    ext_c    = XW'({1'b1, in_mant});
    lead_c   = $signed(32'(in_exp)) - BIAS + int'(F_FRAC);
    if (in_exp == '0) begin
      s1_mag_c = '0;
    end else if ((in_exp == '1) || (lead_c >= int'(W_OUT))) begin
      s1_mag_c = '1;
    end else if (lead_c < 0) begin
      s1_mag_c = '0;
    end else if (lead_c >= int'(n_mant)) begin
      s1_mag_c = W_OUT'(ext_c << (lead_c - int'(n_mant)));
    end else begin
      s1_mag_c = W_OUT'(ext_c >> (int'(n_mant) - lead_c));
    end
  end

  // S1 register.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_vld  <= 1'b0;
      s1_sign <= 1'b0;
      s1_mag  <= '0;
    end else begin
      s1_vld  <= valid;
      s1_sign <= in_sign;
      s1_mag  <= s1_mag_c;
    end
  end

  // S2 clamp to the symmetric range and apply sign (negating zero yields zero).
  always_comb begin
    clamp_c   = (s1_mag > MAXP);
    abs_c     = clamp_c ? MAXP : s1_mag;
    s2_data_c = s1_sign ? (W_OUT'(0) - abs_c) : abs_c;
  end

  // S2 register and sticky saturation flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      s2_vld  <= 1'b0;
      s2_data <= '0;
      sat     <= 1'b0;
    end else begin
      s2_vld  <= s1_vld;
      s2_data <= s2_data_c;
      sat     <= sat | (s1_vld & clamp_c);
    end
  end

  // FIFO control: push accepted when not full or when a pop frees a slot the same cycle.
  always_comb begin
    pop_c    = out_valid & out_ready;
    full_c   = (level == LW'(DEPTH));
    push_c   = s2_vld & (~full_c | pop_c);
    drop_c   = s2_vld & full_c & ~pop_c;
    rd_nxt_c = pop_c ? (rd_ptr + PW'(1)) : rd_ptr;
    remain_c = level - LW'(pop_c);
    level_nxt_c = remain_c + LW'(push_c);
    if (level_nxt_c == '0) begin
      head_nxt_c = out_data;
    end else if (remain_c == '0) begin
      head_nxt_c = s2_data;
    end else begin
      head_nxt_c = mem[rd_nxt_c];
    end
  end

  // FIFO storage; contents need no reset since level gates visibility.
  always_ff @(posedge clk) begin
    if (push_c) begin
      mem[wr_ptr] <= s2_data;
    end
  end

  // FIFO pointers, occupancy, registered head and sticky overrun.
  always_ff @(posedge clk) begin
    if (rst) begin
      rd_ptr    <= '0;
      wr_ptr    <= '0;
      level     <= '0;
      out_valid <= 1'b0;
      out_data  <= '0;
      overrun   <= 1'b0;
    end else begin
      rd_ptr    <= rd_nxt_c;
      wr_ptr    <= push_c ? (wr_ptr + PW'(1)) : wr_ptr;
      level     <= level_nxt_c;
      out_valid <= (level_nxt_c != '0);
      out_data  <= head_nxt_c;
      overrun   <= overrun | drop_c;
    end
  end

`ifdef FLP_SINK_DROPCNT_EN
  // Dropped-sample counter, saturating at all ones.
  always_ff @(posedge clk) begin
    if (rst) begin
      drop_cnt <= '0;
    end else if (drop_c && (drop_cnt != 16'hFFFF)) begin
      drop_cnt <= drop_cnt + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_flp_result_sink.sv
// Bench for flp_result_sink (n_exp=8, n_mant=23, W_OUT=16, F_FRAC=14, DEPTH=4).
// Expected fixed-point values come from a real-arithmetic float model and are
// queued when a sample is driven, then popped as the DUT hands samples out.
module tb_flp_result_sink;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] fin;
  logic        valid;
  logic [15:0] out_data;
  logic        out_valid;
  logic        out_ready;
  logic [2:0]  level;
  logic        sat;
  logic        overrun;
`ifdef FLP_SINK_DROPCNT_EN
  logic [15:0] drop_cnt;
`endif

  int checks = 0;
  int passes = 0;
  logic [15:0] exp_q[$];

  always #5 clk = ~clk;

  flp_result_sink #(
    .n_exp(8), .n_mant(23), .W_OUT(16), .F_FRAC(14), .DEPTH(4)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in(fin),
    .valid(valid),
    .out_data(out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .level(level),
    .sat(sat),
    .overrun(overrun)
`ifdef FLP_SINK_DROPCNT_EN
    ,
    .drop_cnt(drop_cnt)
`endif
  );

  // Reference conversion using real arithmetic.
  function automatic logic [15:0] model(input logic [31:0] x);
    real v;
    int  mag;
    int  ex;
    ex = int'(x[30:23]);
    if (ex == 0) begin
      mag = 0;
    end else if (ex == 255) begin
      mag = 32767;
    end else begin
      v = (1.0 + real'(x[22:0]) / 8388608.0) * (2.0 ** (ex - 127)) * 16384.0;
      if (v >= 32768.0) mag = 32767;
      else mag = $rtoi(v);
    end
    return x[31] ? 16'(-mag) : 16'(mag);
  endfunction

  // Float encoding of the positive value m * 2**-q.
  function automatic logic [31:0] mkf(input int m, input int q);
    int p;
    p = $clog2(m + 1) - 1;
    return {1'b0, 8'(127 + p - q), 23'(m << (23 - p))};
  endfunction

  task automatic do_reset();
    @(posedge clk); #1;
    rst = 1'b1;
    valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    exp_q.delete();
  endtask

  // Drives x for the next cycle and leaves valid high; end_in drops it.
  task automatic send(input logic [31:0] x, input bit keep);
    @(posedge clk); #1;
    fin = x;
    valid = 1'b1;
    if (keep) exp_q.push_back(model(x));
  endtask

  task automatic end_in();
    @(posedge clk); #1;
    valid = 1'b0;
  endtask

  task automatic drain(input int n);
    int got;
    int cyc;
    logic [15:0] e;
    got = 0;
    cyc = 0;
    while (got < n && cyc < 300) begin
      @(negedge clk);
      cyc++;
      if (out_valid && out_ready) begin
        checks++;
        if (exp_q.size() == 0) begin
          $display("FAIL drain_unexpected: got %h with no sample expected", out_data);
        end else begin
          e = exp_q.pop_front();
          if (out_data !== e) $display("FAIL drain_data: got %h expected %h", out_data, e);
          else passes++;
        end
        got++;
      end
    end
    checks++;
    if (got != n) $display("FAIL drain_timeout: got %0d samples expected %0d", got, n);
    else passes++;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    valid = 1'b0;
    out_ready = 1'b0;
    fin = '0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL reset_out_valid: got %b expected 0", out_valid); else passes++;
    checks++; if (out_data !== 16'h0) $display("FAIL reset_out_data: got %h expected 0000", out_data); else passes++;
    checks++; if (level !== 3'd0) $display("FAIL reset_level: got %0d expected 0", level); else passes++;
    checks++; if (sat !== 1'b0) $display("FAIL reset_sat: got %b expected 0", sat); else passes++;
    checks++; if (overrun !== 1'b0) $display("FAIL reset_overrun: got %b expected 0", overrun); else passes++;
`ifdef FLP_SINK_DROPCNT_EN
    checks++; if (drop_cnt !== 16'h0) $display("FAIL reset_drop_cnt: got %0d expected 0", drop_cnt); else passes++;
`endif
    @(posedge clk); #1 rst = 1'b0;
  endtask

  task automatic test_single();
    out_ready = 1'b1;
    send(32'h3F800000, 1'b1);
    end_in();
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL latency_t1: got out_valid %b expected 0", out_valid); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b0) $display("FAIL latency_t2: got out_valid %b expected 0", out_valid); else passes++;
    @(negedge clk);
    checks++; if (out_valid !== 1'b1) $display("FAIL latency_t3: got out_valid %b expected 1", out_valid); else passes++;
    checks++; if (out_data !== 16'h4000) $display("FAIL single_data: got %h expected 4000", out_data); else passes++;
    checks++; if (sat !== 1'b0) $display("FAIL single_sat: got %b expected 0", sat); else passes++;
    void'(exp_q.pop_front());
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL single_empty: got out_valid %b level %0d expected 0 0", out_valid, level); else passes++;
  endtask

  task automatic test_convert();
    out_ready = 1'b1;
    fork
      begin
        send(32'hBF000000, 1'b1);
        send(32'h00000000, 1'b1);
        send(32'h80000001, 1'b1);
        send(32'h3FFFFFFF, 1'b1);
        send(32'hBF800001, 1'b1);
        end_in();
      end
      drain(5);
    join
    checks++; if (sat !== 1'b0) $display("FAIL convert_nosat: got sat %b expected 0", sat); else passes++;
    fork
      begin
        send(32'h40800000, 1'b1);
        send(32'hFF800000, 1'b1);
        send(32'h7FC00000, 1'b1);
        for (int i = 0; i < 8; i++)
          send({1'($urandom_range(0, 1)), 8'($urandom_range(110, 130)), 23'($urandom)}, 1'b1);
        send(mkf(1, 2), 1'b1);
        end_in();
      end
      drain(12);
    join
    repeat (3) @(negedge clk);
    checks++; if (sat !== 1'b1) $display("FAIL convert_sat_sticky: got sat %b expected 1", sat); else passes++;
  endtask

  task automatic test_back_to_back();
    localparam int N = 14;
    do_reset();
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < N; i++) begin
          send(mkf(i + 1, 4), 1'b1);
          if (i == 6) out_ready = 1'b1;
        end
        end_in();
      end
      drain(N);
      begin
        for (int c = 0; c <= N + 1; c++) begin
          @(posedge clk);
          @(negedge clk);
          if (c >= 6) begin
            checks++;
            if (level !== 3'd4 || overrun !== 1'b0)
              $display("FAIL b2b_level: cycle %0d got level %0d overrun %b expected 4 0", c, level, overrun);
            else passes++;
          end
        end
      end
    join
  endtask

  task automatic test_overrun();
    logic [15:0] e;
    do_reset();
    out_ready = 1'b0;
    for (int i = 1; i <= 6; i++) send(mkf(i, 0), i <= 4);
    end_in();
    repeat (4) @(posedge clk);
    @(negedge clk);
    checks++; if (level !== 3'd4) $display("FAIL ovr_level: got %0d expected 4", level); else passes++;
    checks++; if (overrun !== 1'b1) $display("FAIL ovr_flag: got %b expected 1", overrun); else passes++;
`ifdef FLP_SINK_DROPCNT_EN
    checks++; if (drop_cnt !== 16'd2) $display("FAIL ovr_drop_cnt: got %0d expected 2", drop_cnt); else passes++;
`endif
    repeat (2) @(negedge clk);
    checks++; if (out_valid !== 1'b1 || out_data !== 16'h4000)
      $display("FAIL ovr_hold: got valid %b data %h expected 1 4000", out_valid, out_data); else passes++;
    @(posedge clk); #1 out_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk);
      e = exp_q.pop_front();
      checks++;
      if (out_valid !== 1'b1 || out_data !== e || level !== 3'(4 - k))
        $display("FAIL ovr_drain: step %0d got valid %b data %h level %0d expected 1 %h %0d",
                 k, out_valid, out_data, level, e, 4 - k);
      else passes++;
    end
    @(negedge clk);
    checks++; if (out_valid !== 1'b0 || level !== 3'd0)
      $display("FAIL ovr_empty: got valid %b level %0d expected 0 0", out_valid, level); else passes++;
  endtask

  task automatic test_reset_mid();
    int stale;
    out_ready = 1'b0;
    for (int i = 0; i < 5; i++) send(mkf(i + 1, 2), 1'b0);
    @(posedge clk); #1;
    valid = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    checks++; if (level !== 3'd3) $display("FAIL mid_pre_level: got %0d expected 3", level); else passes++;
    @(posedge clk); #1 rst = 1'b0;
    exp_q.delete();
    @(negedge clk);
    checks++; if (level !== 3'd0 || out_valid !== 1'b0)
      $display("FAIL mid_flush: got level %0d valid %b expected 0 0", level, out_valid); else passes++;
    checks++; if (sat !== 1'b0 || overrun !== 1'b0)
      $display("FAIL mid_flags: got sat %b overrun %b expected 0 0", sat, overrun); else passes++;
`ifdef FLP_SINK_DROPCNT_EN
    checks++; if (drop_cnt !== 16'd0) $display("FAIL mid_drop_cnt: got %0d expected 0", drop_cnt); else passes++;
`endif
    out_ready = 1'b1;
    stale = 0;
    repeat (8) begin
      @(negedge clk);
      if (out_valid !== 1'b0) stale++;
    end
    checks++; if (stale != 0) $display("FAIL mid_stale: got %0d stale cycles expected 0", stale); else passes++;
    fork
      begin
        send(32'hBE800000, 1'b1);
        end_in();
      end
      drain(1);
    join
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_single();
    test_convert();
    test_back_to_back();
    test_overrun();
    test_reset_mid();
    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
